// File: rtl/sdram_axi_tester_pkg.sv
// rtl/sdram_axi_tester_pkg.sv - shared state encoding, AXI constants and data pattern for the SDRAM AXI tester
package sdram_axi_tester_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_AW   = 4'd1,
    ST_W    = 4'd2,
    ST_B    = 4'd3,
    ST_AR   = 4'd4,
    ST_R    = 4'd5,
    ST_DONE = 4'd6
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [31:0] pattern(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/sdram_axi_tester.sv
// rtl/sdram_axi_tester.sv - AXI4 initiator that writes a seeded pattern over a region, reads it back and checks every beat
module sdram_axi_tester
  import sdram_axi_tester_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_BURSTS = 16,
  parameter logic [3:0]  AXI_ID     = 4'h0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  input  logic        outport_awready_i,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  input  logic        outport_wready_i,
  output logic        outport_bready_o,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  output logic        outport_rready_o,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  output logic [3:0]  state_o
);

  localparam logic [7:0]  LEN         = 8'(BURST_LEN - 1);
  localparam logic [8:0]  LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [31:0] LAST_BURST  = 32'(NUM_BURSTS - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);

  state_t      r_state;
  logic [31:0] r_seed;
  logic [31:0] r_burst_cnt;
  logic [8:0]  r_beat;
  logic        r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
  logic [31:0] r_awaddr, r_araddr, r_wdata;
  logic [3:0]  r_id, r_wstrb;
  logic [7:0]  r_len;
  logic [1:0]  r_burst_type;
  logic        r_busy, r_done;
  logic [15:0] r_err_count;
  logic [31:0] r_first_err;

  logic [8:0]  w_beat_next;
  logic [31:0] w_beat_addr;
  logic        w_last_beat;
  logic        w_b_err, w_r_err;
  logic        w_err_event;
  logic [31:0] w_err_addr;

  assign w_beat_next = r_beat + 9'd1;
  assign w_beat_addr = r_araddr + {21'b0, r_beat, 2'b00};
  assign w_last_beat = (r_beat == LAST_BEAT);

  assign w_b_err = (outport_bresp_i != AXI_RESP_OKAY) || (outport_bid_i != AXI_ID);
  // rlast is only checked against the internal beat count; it never ends a burst
  assign w_r_err = (outport_rresp_i != AXI_RESP_OKAY) || (outport_rid_i != AXI_ID) ||
                   (outport_rdata_i != pattern(w_beat_addr, r_seed)) ||
                   (outport_rlast_i != w_last_beat);

  always_comb begin
    w_err_event = 1'b0;
    w_err_addr  = r_awaddr;
    if (r_state == ST_B && r_bready && outport_bvalid_i) begin
      w_err_event = w_b_err;
    end else if (r_state == ST_R && r_rready && outport_rvalid_i) begin
      w_err_event = w_r_err;
      w_err_addr  = w_beat_addr;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_seed       <= '0;
      r_burst_cnt  <= '0;
      r_beat       <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_wlast      <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_araddr     <= '0;
      r_wdata      <= '0;
      r_id         <= '0;
      r_wstrb      <= '0;
      r_len        <= '0;
      r_burst_type <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_count  <= '0;
      r_first_err  <= '0;
    end else begin
      if (w_err_event) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        if (r_err_count == 16'd0) r_first_err <= w_err_addr;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state      <= ST_AW;
            r_seed       <= seed_i;
            r_awvalid    <= 1'b1;
            r_awaddr     <= BASE_ADDR;
            r_id         <= AXI_ID;
            r_len        <= LEN;
            r_burst_type <= AXI_BURST_INCR;
            r_wstrb      <= 4'hF;
            r_burst_cnt  <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err_count  <= '0;
            r_first_err  <= '0;
          end
        end
        ST_AW: begin
          if (outport_awready_i) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wdata   <= pattern(r_awaddr, r_seed);
            r_wlast   <= (LAST_BEAT == 9'd0);
            r_beat    <= '0;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (outport_wready_i) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= ST_B;
            end else begin
              r_beat  <= w_beat_next;
              r_wdata <= pattern(r_awaddr + {21'b0, w_beat_next, 2'b00}, r_seed);
              r_wlast <= (w_beat_next == LAST_BEAT);
            end
          end
        end
        ST_B: begin
          if (outport_bvalid_i) begin
            r_bready <= 1'b0;
            if (r_burst_cnt == LAST_BURST) begin
              r_burst_cnt <= '0;
              r_araddr    <= BASE_ADDR;
              r_arvalid   <= 1'b1;
              r_state     <= ST_AR;
            end else begin
              r_burst_cnt <= r_burst_cnt + 32'd1;
              r_awaddr    <= r_awaddr + BURST_BYTES;
              r_awvalid   <= 1'b1;
              r_state     <= ST_AW;
            end
          end
        end
        ST_AR: begin
          if (outport_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_beat    <= '0;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (outport_rvalid_i) begin
            if (w_last_beat) begin
              r_rready <= 1'b0;
              if (r_burst_cnt == LAST_BURST) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_burst_cnt <= r_burst_cnt + 32'd1;
                r_araddr    <= r_araddr + BURST_BYTES;
                r_arvalid   <= 1'b1;
                r_state     <= ST_AR;
              end
            end else begin
              r_beat <= w_beat_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign outport_awvalid_o = r_awvalid;
  assign outport_awaddr_o  = r_awaddr;
  assign outport_awid_o    = r_id;
  assign outport_awlen_o   = r_len;
  assign outport_awburst_o = r_burst_type;
  assign outport_wvalid_o  = r_wvalid;
  assign outport_wdata_o   = r_wdata;
  assign outport_wstrb_o   = r_wstrb;
  assign outport_wlast_o   = r_wlast;
  assign outport_bready_o  = r_bready;
  assign outport_arvalid_o = r_arvalid;
  assign outport_araddr_o  = r_araddr;
  assign outport_arid_o    = r_id;
  assign outport_arlen_o   = r_len;
  assign outport_arburst_o = r_burst_type;
  assign outport_rready_o  = r_rready;
  assign busy_o            = r_busy;
  assign done_o            = r_done;
  assign pass_o            = r_done && (r_err_count == 16'd0);
  assign err_count_o       = r_err_count;
  assign first_err_addr_o  = r_first_err;
  assign state_o           = r_state;

endmodule

// File: tb/tb_sdram_axi_tester.sv
// tb/tb_sdram_axi_tester.sv - memory-slave scoreboard bench for sdram_axi_tester
module tb_sdram_axi_tester;

  localparam int          BL   = 4;
  localparam int          NB   = 2;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [3:0]  ID   = 4'h3;

  logic        clk = 1'b0;
  logic        rstn_i, start_i;
  logic [31:0] seed_i;
  logic        awvalid, awready, wvalid, wlast, wready, bready, bvalid;
  logic        arvalid, arready, rready, rvalid, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid, state_o;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_count_o;
  logic [31:0] first_err_addr_o;

  always #5 clk = ~clk;

  sdram_axi_tester #(.BASE_ADDR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB), .AXI_ID(ID)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .seed_i(seed_i),
    .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awid_o(awid),
    .outport_awlen_o(awlen), .outport_awburst_o(awburst), .outport_awready_i(awready),
    .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
    .outport_wlast_o(wlast), .outport_wready_i(wready),
    .outport_bready_o(bready), .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bid_i(bid),
    .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arid_o(arid),
    .outport_arlen_o(arlen), .outport_arburst_o(arburst), .outport_arready_i(arready),
    .outport_rready_o(rready), .outport_rvalid_i(rvalid), .outport_rdata_i(rdata),
    .outport_rresp_i(rresp), .outport_rid_i(rid), .outport_rlast_i(rlast),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o), .state_o(state_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [31:0] data; logic last; } wbeat_t;
  wbeat_t      exp_w[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [31:0] mem [logic [31:0]];

  // Slave fault/stall configuration
  int          bresp_err_burst = -1;
  bit          corrupt_en = 0;
  logic [31:0] corrupt_addr = '0;
  bit          stall_en = 0;
  int          aw_wait = 0, w_wait = 0, b_count = 0, w_hs_total = 0;

  bit          b_pending, b_fire, r_start, r_fire;
  int          r_beat;
  logic [31:0] r_base, w_addr;
  bit          p_awvalid, p_aw_hs, p_wvalid, p_w_hs, aw_hs, w_hs;
  logic [31:0] p_awaddr, p_wdata;
  logic        p_wlast;

  task automatic drive_r();
    logic [31:0] a, d;
    a = r_base + 32'(r_beat * 4);
    d = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
    if (corrupt_en && a == corrupt_addr) d = d ^ 32'h1;
    rdata = d;
    rlast = (r_beat == BL - 1);
    rresp = 2'b00;
    rid   = ID;
  endtask

  task automatic slave_reset();
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
    b_pending = 0; b_fire = 0; r_start = 0; r_fire = 0; r_beat = 0;
    p_awvalid = 0; p_aw_hs = 0; p_wvalid = 0; p_w_hs = 0;
  endtask

  // Slave + monitor: decides handshakes on the negedge, compares popped expectations
  initial begin
    slave_reset();
    forever begin
      @(negedge clk);
      if (!rstn_i) begin
        slave_reset();
        continue;
      end
      if (p_awvalid && !p_aw_hs) begin
        check("aw_valid_held", awvalid, 1);
        check("aw_addr_stable", awaddr, p_awaddr);
      end
      if (p_wvalid && !p_w_hs) begin
        check("w_valid_held", wvalid, 1);
        check("w_data_stable", wdata, p_wdata);
        check("w_last_stable", wlast, p_wlast);
      end
      if (b_fire) begin bvalid = 0; b_fire = 0; end
      if (b_pending) begin
        bvalid = 1; bid = ID;
        bresp = (b_count == bresp_err_burst) ? 2'b10 : 2'b00;
        b_count++; b_pending = 0;
      end
      if (bvalid && bready) b_fire = 1;
      if (r_fire) begin
        r_fire = 0; r_beat++;
        if (r_beat == BL) rvalid = 0; else drive_r();
      end
      if (r_start) begin r_start = 0; r_beat = 0; rvalid = 1; drive_r(); end
      if (rvalid && rready) r_fire = 1;
      if (stall_en && awvalid && aw_wait > 0) begin awready = 0; aw_wait--; end
      else awready = 1;
      aw_hs = awvalid && awready;
      if (aw_hs) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else check("aw_addr", awaddr, exp_aw.pop_front());
        check("aw_len_burst_id", {awlen, awburst, awid}, {8'(BL - 1), 2'b01, ID});
        w_addr = awaddr;
        aw_wait = stall_en ? 5 : 0;
      end
      if (stall_en && wvalid && w_wait > 0 && $urandom_range(0, 1) == 1) begin wready = 0; w_wait--; end
      else wready = 1;
      w_hs = wvalid && wready;
      if (w_hs) begin
        wbeat_t e;
        w_hs_total++;
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          e = exp_w.pop_front();
          check("w_addr", w_addr, e.addr);
          check("w_data", wdata, e.data);
          check("w_last", wlast, e.last);
        end
        check("w_strb", wstrb, 4'hF);
        mem[w_addr] = wdata;
        w_addr += 4;
        if (wlast) begin b_pending = 1; w_wait = stall_en ? 5 : 0; end
      end
      arready = 1;
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else check("ar_addr", araddr, exp_ar.pop_front());
        check("ar_len_burst_id", {arlen, arburst, arid}, {8'(BL - 1), 2'b01, ID});
        r_base = araddr; r_start = 1;
      end
      p_awvalid = awvalid; p_aw_hs = aw_hs; p_awaddr = awaddr;
      p_wvalid = wvalid; p_w_hs = w_hs; p_wdata = wdata; p_wlast = wlast;
    end
  end

  // Reference: the whole pass as a list of expected transactions
  task automatic begin_run(input logic [31:0] seed);
    exp_w.delete(); exp_aw.delete(); exp_ar.delete();
    for (int k = 0; k < NB; k++) begin
      exp_aw.push_back(BASE + 32'(k * BL * 4));
      exp_ar.push_back(BASE + 32'(k * BL * 4));
      for (int b = 0; b < BL; b++) begin
        wbeat_t e;
        e.addr = BASE + 32'((k * BL + b) * 4);
        e.data = e.addr ^ seed;
        e.last = (b == BL - 1);
        exp_w.push_back(e);
      end
    end
    b_count = 0; w_hs_total = 0;
    aw_wait = stall_en ? 5 : 0; w_wait = stall_en ? 5 : 0;
    seed_i = seed; start_i = 1;
    @(negedge clk);
    start_i = 0;
    check("awvalid_after_start", awvalid, 1);
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic finish_run();
    int n = 0;
    int exp_err = 0;
    logic [31:0] exp_first = '0;
    while (!done_o && n < 2000) begin @(negedge clk); n++; end
    check("done_reached", done_o, 1);
    if (bresp_err_burst >= 0 && bresp_err_burst < NB) begin
      exp_err++; exp_first = BASE + 32'(bresp_err_burst * BL * 4);
    end
    if (corrupt_en && corrupt_addr >= BASE && corrupt_addr < BASE + 32'(NB * BL * 4)) begin
      if (exp_err == 0) exp_first = corrupt_addr;
      exp_err++;
    end
    check("err_count", err_count_o, exp_err);
    check("first_err_addr", first_err_addr_o, exp_first);
    check("pass", pass_o, exp_err == 0);
    check("busy_done", {busy_o, state_o}, {1'b0, 4'd6});
    check("writes_drained", exp_w.size(), 0);
    check("reads_drained", exp_ar.size(), 0);
  endtask

  initial begin
    int n;
    rstn_i = 0; start_i = 0; seed_i = '0;
    repeat (3) @(negedge clk);
    check("rst_valids", {awvalid, wvalid, wlast, arvalid, bready, rready}, 0);
    check("rst_status", {busy_o, done_o, pass_o, state_o}, 0);
    check("rst_err_count", err_count_o, 0);
    check("rst_first_err", first_err_addr_o, 0);
    check("rst_addr_data", awaddr | araddr | wdata, 0);
    check("rst_id_len", {awid, arid, awlen, arlen, awburst, arburst, wstrb}, 0);
    rstn_i = 1;
    @(negedge clk);

    begin_run(32'h0); finish_run();

    corrupt_en = 1; corrupt_addr = 32'h14;
    begin_run($urandom); finish_run();
    corrupt_en = 0;

    bresp_err_burst = 1;
    begin_run($urandom); finish_run();
    bresp_err_burst = -1;

    // Restart from DONE with a mid-test pulse that must be ignored
    begin_run(32'h1234_5678);
    repeat (6) @(negedge clk);
    seed_i = 32'hA5A5_A5A5; start_i = 1;
    @(negedge clk);
    start_i = 0;
    finish_run();
    begin_run(32'hFFFF_FFFF); finish_run();

    stall_en = 1;
    for (int i = 0; i < 3; i++) begin begin_run($urandom); finish_run(); end
    stall_en = 0;

    // Asynchronous reset while W beat 2 is on the bus
    begin_run($urandom);
    n = 0;
    while (w_hs_total < 2 && n < 200) begin @(negedge clk); n++; end
    check("reached_w_beat2", w_hs_total, 2);
    @(posedge clk);
    #2 rstn_i = 0;
    #1;
    check("reset_valids_drop", {awvalid, wvalid, arvalid, bready, rready, wlast}, 0);
    check("reset_state", {busy_o, done_o, state_o}, 0);
    repeat (2) @(negedge clk);
    rstn_i = 1;
    @(negedge clk);
    begin_run($urandom); finish_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sdram_axi_tester.md
# sdram_axi_tester

AXI4 initiator that exercises the SDRAM controller's AXI slave port from the PL side, in place of the PS master. On `start_i` it writes a deterministic pattern over a contiguous region using INCR bursts, reads the region back, and compares every beat. It reports busy/done/pass status, an error count, the first failing address, and a 4-bit state code that can drive the board `led` pins.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: first byte address of the test region; must be 4-byte aligned.
- `BURST_LEN`, 8: beats per burst, 1..256. `awlen` and `arlen` are `BURST_LEN-1`.
- `NUM_BURSTS`, 16: number of bursts per pass, ≥1. Region size is `NUM_BURSTS*BURST_LEN*4` bytes.
- `AXI_ID`, 4'h0: value driven on `awid` and `arid`; also the expected `bid` and `rid`.

Ports (clock and reset first):
- `clk_i` in 1: single clock, shared with the slave.
- `rstn_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse that starts a test; ignored while `busy_o`=1.
- `seed_i` in 32: pattern seed, latched on start.
- `outport_aw{valid,addr,id,len,burst}_o`, `outport_awready_i`: write address channel, widths 1/32/4/8/2.
- `outport_w{valid,data,strb,last}_o`, `outport_wready_i`: write data channel, widths 1/32/4/1.
- `outport_bready_o`, `outport_b{valid,resp,id}_i`: write response channel, widths 1/1/2/4.
- `outport_ar{valid,addr,id,len,burst}_o`, `outport_arready_i`: read address channel, same widths as AW.
- `outport_rready_o`, `outport_r{valid,data,resp,id,last}_i`: read data channel, widths 1/1/32/2/4/1.
- `busy_o` out 1; `done_o` out 1; `pass_o` out 1.
- `err_count_o` out 16: error count, saturating.
- `first_err_addr_o` out 32: byte address of the first error.
- `state_o` out 4: encoded FSM state.

## Operation
- States, encoded on `state_o`: IDLE=0, AW=1, W=2, B=3, AR=4, R=5, DONE=6.
- Transitions:
  - IDLE→AW on `start_i`.
  - AW→W on AW handshake.
  - W→B on the handshake of the `wlast` beat.
  - B→AW while bursts remain; B→AR after the last write burst (burst counter is reset).
  - AR→R on AR handshake.
  - R→AR on the `rlast` beat while bursts remain; R→DONE after the last read burst.
  - DONE→AW on `start_i`; all statistics are cleared.
- Address of burst k: `BASE_ADDR + k*BURST_LEN*4`. Beat address = burst address + beat*4.
- Pattern: `data = beat_addr ^ seed_q`. `wstrb`=4'hF. `awburst` and `arburst`=2'b01 (INCR).
- One transaction outstanding at a time; AW, W and B are strictly sequential.
- An error is counted for any of:
  - `bresp` ≠ 0 or `bid` ≠ `AXI_ID`;
  - `rresp` ≠ 0, `rid` ≠ `AXI_ID`, or `rdata` ≠ expected;
  - `rlast` asserted on a beat other than the last, or deasserted on the last beat.
  At most one error is counted per beat. A wrong `rlast` does not alter beat counting: the burst ends on the internal beat count.
- `err_count_o` saturates at 16'hFFFF. `first_err_addr_o` captures the beat address (for B errors, the burst address) of the first error only.
- `pass_o` = `done_o` && `err_count_o`==0.

## Timing
- Reset values:
  - all `*valid_o`, `*ready_o`, `wlast`, `busy_o`, `done_o`, `pass_o` = 0;
  - `err_count_o` = 0, `first_err_addr_o` = 0, `state_o` = 0;
  - AXI address/data/id outputs = 0.
- `awvalid` rises the cycle after `start_i`. Once raised, a valid and its payload hold stable until the handshake and never drop early.
- `wvalid` is high throughout W. With `wready` held at 1, a burst takes `BURST_LEN` cycles.
- `bready`=1 only in B; `rready`=1 only in R. Both are registered.
- `busy_o`=1 in every state except IDLE and DONE. `done_o` is a level that stays high until the next `start_i`.
- Reset asserted mid-burst: all outputs go to reset values immediately. The slave shares the reset, so the protocol break is acceptable.
- Best-case length with a zero-wait slave and one-cycle B/R latency: about `NUM_BURSTS*(2*BURST_LEN+6)` cycles.

## Structure
- Package `sdram_axi_tester_pkg` holds:
  - the state enum, 4-bit;
  - constants `AXI_BURST_INCR`=2'b01 and `AXI_RESP_OKAY`=2'b00;
  - function `pattern(addr, seed)`.
- Single module with no sub-module. Beat counter, burst counter and checker live in one file.

## Test plan
- BURST_LEN=4, NUM_BURSTS=2, seed=0, ideal slave model → 8 writes with data equal to address (0x0, 0x4, …, 0x1C); `done_o`=1, `pass_o`=1, `err_count_o`=0.
- Slave corrupts the read at 0x14 (XOR 0x1) → `err_count_o`=1, `first_err_addr_o`=0x14, `pass_o`=0.
- Slave returns `bresp`=2'b10 on burst 1 (BURST_LEN=4, BASE_ADDR=0) → `err_count_o`=1, `first_err_addr_o`=0x10.
- Slave stalls `awready` and `wready` for 5 random cycles each → valids and payloads stay stable throughout; test passes.
- `start_i` pulsed while busy, then again after done → the mid-test pulse is ignored; the second run clears stats, and with seed=0xFFFF_FFFF the first write carries `wdata`=0xFFFF_FFFF.
- `rstn_i` asserted during W beat 2 → all valids drop in the same cycle and `state_o`=0; a subsequent start runs a clean pass.
